// File: rtl/conv1_feed_ctrl.sv
// Frame sequencer for conv1: streams one WIDTHxHEIGHT image from pixel memory into
// the 3x3 line buffer, counts emitted windows and ends the frame on count, timeout or abort.
module conv1_feed_ctrl #(
    parameter  int WIDTH   = 28,
    parameter  int HEIGHT  = 28,
    parameter  int TIMEOUT = 8,
    localparam int NPIX    = WIDTH * HEIGHT,
    localparam int NWIN    = (WIDTH - 2) * (HEIGHT - 2),
    localparam int A_BITS  = $clog2(NPIX),
    localparam int C_BITS  = $clog2(NWIN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [A_BITS-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              buf_valid_in,
    output logic [7:0]        buf_pixel_in,
    output logic              buf_rst_n,
    input  logic              buf_valid_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [C_BITS-1:0] win_count
);

    localparam int T_BITS = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [A_BITS-1:0] addr_r;
    logic              valid_in_r;
    logic              brst_r;
    logic [1:0]        abort_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [C_BITS-1:0] win_r;
    logic [T_BITS-1:0] tmo_r;

    logic              rd_s;
    logic              accept_s;
    logic              abort_s;
    logic              count_s;
    logic              last_rd_s;
    logic              win_hit_s;
    logic              tmo_hit_s;
    logic              err_set_s;
    logic [C_BITS-1:0] win_next_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort outranks every other exit from FETCH/DRAIN
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = accept_s ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (abort_s) begin
                    state_s = S_DONE;
                end else if (last_rd_s) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DRAIN: state_s = (abort_s || win_hit_s || tmo_hit_s) ? S_DONE : S_DRAIN;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM output/decode logic; the window count takes precedence over a coincident timeout
    always_comb begin
        rd_s     = 1'b0;
        accept_s = 1'b0;
        abort_s  = 1'b0;
        case (state_r)
            S_IDLE:  accept_s = start;
            S_FETCH: begin
                rd_s    = !hold;
                abort_s = abort;
            end
            S_DRAIN: abort_s = abort;
            S_DONE:  rd_s = 1'b0;
            default: rd_s = 1'b0;
        endcase
        count_s    = ((state_r == S_FETCH) || (state_r == S_DRAIN)) && buf_valid_out
                     && !abort && (win_r != C_BITS'(NWIN));
        win_next_s = count_s ? (win_r + C_BITS'(1)) : win_r;
        last_rd_s  = rd_s && (addr_r == A_BITS'(NPIX - 1));
        win_hit_s  = (win_next_s == C_BITS'(NWIN));
        tmo_hit_s  = !buf_valid_out && (tmo_r == T_BITS'(TIMEOUT - 1));
        err_set_s  = (state_r == S_DRAIN) && !abort && !win_hit_s && tmo_hit_s;
    end

    // Address, window count, timeout and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {A_BITS{1'b0}};
            valid_in_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            win_r      <= {C_BITS{1'b0}};
            tmo_r      <= {T_BITS{1'b0}};
        end else begin
            valid_in_r <= rd_s && !abort_s;
            busy_r     <= (state_s == S_FETCH) || (state_s == S_DRAIN);
            done_r     <= (state_s == S_DONE);
            if (accept_s) begin
                addr_r <= {A_BITS{1'b0}};
                win_r  <= {C_BITS{1'b0}};
                err_r  <= 1'b0;
            end else begin
                if (rd_s && !last_rd_s) begin
                    addr_r <= addr_r + A_BITS'(1);
                end
                win_r <= win_next_s;
                err_r <= err_r | err_set_s;
            end
            if ((state_r == S_DRAIN) && !buf_valid_out && !tmo_hit_s) begin
                tmo_r <= tmo_r + T_BITS'(1);
            end else begin
                tmo_r <= {T_BITS{1'b0}};
            end
        end
    end

    // Line-buffer reset: released one clock after rst_n, held low two cycles after abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brst_r      <= 1'b0;
            abort_cnt_r <= 2'd0;
        end else if (abort_s) begin
            brst_r      <= 1'b0;
            abort_cnt_r <= 2'd2;
        end else if (abort_cnt_r != 2'd0) begin
            brst_r      <= (abort_cnt_r == 2'd1);
            abort_cnt_r <= abort_cnt_r - 2'd1;
        end else begin
            brst_r      <= 1'b1;
        end
    end

    assign mem_rd_en    = rd_s;
    assign mem_addr     = addr_r;
    assign buf_valid_in = valid_in_r;
    assign buf_pixel_in = mem_rd_data;
    assign buf_rst_n    = brst_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign win_count    = win_r;

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Scoreboard bench for conv1_feed_ctrl: a memory model and a line-buffer stub surround
// the DUT; expected reads, pixels and frame results are queued and checked by a monitor.
module tb_conv1_feed_ctrl;

    localparam int W      = 28;
    localparam int H      = 28;
    localparam int TO     = 8;
    localparam int NPIX   = W * H;
    localparam int NWIN   = (W - 2) * (H - 2);
    localparam int A_BITS = $clog2(NPIX);
    localparam int C_BITS = $clog2(NWIN + 1);

    typedef struct {
        int cyc;
        int wc;
        int er;
    } res_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              hold;
    logic              mem_rd_en;
    logic [A_BITS-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              buf_valid_in;
    logic [7:0]        buf_pixel_in;
    logic              buf_rst_n;
    logic              buf_valid_out;
    logic              busy;
    logic              done;
    logic              err;
    logic [C_BITS-1:0] win_count;

    logic [7:0] mem [NPIX];
    int         cyc = 0;
    int         e0 = 0;
    int         win_limit = NWIN;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         addr_q[$];
    int         pix_q[$];
    res_t       res_q[$];
    res_t       mon_r;
    int         mon_v;

    int   sb_cnt;
    int   sb_i1;
    int   sb_i2;
    logic sb_d1;
    logic sb_d2;

    conv1_feed_ctrl #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .buf_valid_in(buf_valid_in), .buf_pixel_in(buf_pixel_in), .buf_rst_n(buf_rst_n),
        .buf_valid_out(buf_valid_out), .busy(busy), .done(done), .err(err),
        .win_count(win_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read pixel memory
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // line-buffer stub: window for pixel k two cycles after its buf_valid_in, suppressed past win_limit
    always @(posedge clk) begin
        if (!buf_rst_n) begin
            sb_cnt <= 0; sb_d1 <= 1'b0; sb_d2 <= 1'b0; sb_i1 <= 0; sb_i2 <= 0;
        end else begin
            sb_d1 <= buf_valid_in && (sb_cnt / W >= 2) && (sb_cnt % W >= 2);
            sb_i1 <= (sb_cnt / W - 2) * (W - 2) + (sb_cnt % W - 2);
            sb_d2 <= sb_d1;
            sb_i2 <= sb_i1;
            if (buf_valid_in) sb_cnt <= (sb_cnt == NPIX - 1) ? 0 : sb_cnt + 1;
        end
    end
    assign buf_valid_out = sb_d2 && (sb_i2 < win_limit);

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name, input int act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a read, a pixel or done
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) bad("unexpected_read", int'(mem_addr));
                else begin
                    mon_v = addr_q.pop_front();
                    chk("mem_addr", int'(mem_addr), mon_v);
                end
            end
            if (buf_valid_in) begin
                if (pix_q.size() == 0) bad("unexpected_pixel", int'(buf_pixel_in));
                else begin
                    mon_v = pix_q.pop_front();
                    chk("buf_pixel_in", int'(buf_pixel_in), mon_v);
                end
            end
            if (done) begin
                if (res_q.size() == 0) bad("unexpected_done", cyc);
                else begin
                    mon_r = res_q.pop_front();
                    chk("done_cycle", cyc, mon_r.cyc);
                    chk("done_win_count", int'(win_count), mon_r.wc);
                    chk("done_err", int'(err), mon_r.er);
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    function automatic int n_windows(input int k);
        int n = 0;
        for (int p = 0; p <= k; p++) if ((p / W >= 2) && (p % W >= 2)) n++;
        return n;
    endfunction

    function automatic logic pick_hold(input int mode, input int t);
        case (mode)
            1:       return ((t >= 100) && (t < 105)) || ((t >= 788) && (t < 791));
            2:       return ($urandom_range(0, 9) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_buf_valid_in"}, int'(buf_valid_in), 0);
        chk({tag, "_buf_rst_n"}, int'(buf_rst_n), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_win_count"}, int'(win_count), 0);
    endtask

    task automatic fill_mem(input bit rnd);
        for (int a = 0; a < NPIX; a++) mem[a] = rnd ? 8'($urandom) : 8'(a);
    endtask

    // one frame: hmode 0 none / 1 fixed schedule / 2 random; abort_t<0 means no abort
    task automatic run_frame(input int hmode, input int limit, input int abort_t,
                             input bit rst_mid, input bit pulses);
        int   reads, holds, t, entry, exp_done, final_wc;
        res_t r;
        reads = 0; holds = 0; entry = -1; exp_done = -1;
        final_wc  = (limit >= NWIN) ? NWIN : limit;
        win_limit = limit;
        if (abort_t >= 0) begin
            for (int a = 0; a <= abort_t; a++) addr_q.push_back(a);
            for (int a = 0; a < abort_t; a++) pix_q.push_back(int'(mem[a]));
            final_wc = n_windows(abort_t - 4);
        end else begin
            for (int a = 0; a < NPIX; a++) begin
                addr_q.push_back(a);
                pix_q.push_back(int'(mem[a]));
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        e0 = cyc;
        start = 1'b0;
        chk("err_cleared", int'(err), 0);
        chk("win_count_cleared", int'(win_count), 0);
        chk("busy_on_start", int'(busy), 1);
        for (t = 0; t < 4 * NPIX; t++) begin
            if (rst_mid && (entry >= 0) && (t == entry + 1)) begin
                res_q.delete();
                rst_n = 1'b0;
                #1;
                check_reset_vals("rst_mid");
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                chk("rst_mid_brst_held", int'(buf_rst_n), 0);
                @(posedge clk); #1;
                chk("rst_mid_brst_release", int'(buf_rst_n), 1);
                final_wc = 0;
                break;
            end
            abort = 1'b0;
            start = 1'b0;
            if (abort_t >= 0 && t == abort_t + 1) begin
                chk("abort_brst_low1", int'(buf_rst_n), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_valid_in", int'(buf_valid_in), 0);
            end
            if (abort_t >= 0 && t == abort_t + 2) chk("abort_brst_low2", int'(buf_rst_n), 0);
            if (abort_t >= 0 && t == abort_t + 3) begin
                chk("abort_brst_release", int'(buf_rst_n), 1);
                break;
            end
            hold = pick_hold(hmode, t);
            if ((reads < NPIX) && !(abort_t >= 0 && t > abort_t)) begin
                if (abort_t >= 0 && t == abort_t) begin
                    abort = 1'b1;
                    hold  = 1'b0;
                    r.cyc = e0 + t + 1; r.wc = final_wc; r.er = 0;
                    res_q.push_back(r);
                end else if (hold) begin
                    holds++;
                end else begin
                    reads++;
                    if (reads == NPIX) begin
                        entry    = t + 1;
                        exp_done = (limit >= NWIN) ? e0 + entry + 3 : e0 + entry + TO;
                        r.cyc = exp_done; r.wc = final_wc; r.er = (limit < NWIN) ? 1 : 0;
                        res_q.push_back(r);
                    end
                end
            end
            if (pulses && t == 50) start = 1'b1;
            if (pulses && exp_done >= 0 && e0 + t == exp_done) start = 1'b1;
            if (exp_done >= 0 && e0 + t >= exp_done + 3) break;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        chk("frame_result_seen", res_q.size(), 0);
        if (!rst_mid && abort_t < 0) chk("addr_stays_last", int'(mem_addr), NPIX - 1);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_win_count", int'(win_count), final_wc);
        chk("holds_seen_ge0", (holds >= 0) ? int'(done) : 1, 0);
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        rst_n = 1'b1;
        fill_mem(1'b0);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("por_brst_held", int'(buf_rst_n), 0);
        @(posedge clk); #1;
        chk("por_brst_release", int'(buf_rst_n), 1);

        run_frame(0, NWIN, -1, 1'b0, 1'b0);
        run_frame(1, NWIN, -1, 1'b0, 1'b1);
        fill_mem(1'b1);
        run_frame(2, 600, -1, 1'b0, 1'b0);
        fill_mem(1'b1);
        run_frame(2, $urandom_range(100, NWIN - 10), -1, 1'b0, 1'b0);
        fill_mem(1'b1);
        run_frame(0, NWIN, 300, 1'b0, 1'b0);
        run_frame(2, NWIN, -1, 1'b0, 1'b0);
        run_frame(2, NWIN, -1, 1'b1, 1'b0);
        fill_mem(1'b0);
        run_frame(0, NWIN, -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
